// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store path.
// Accepts one request at a time, waits WAIT_CYCLES edges, performs a
// byte/half/word access (lane-masked store or sign/zero-extended load) and
// holds the response until the requester consumes it. Misaligned,
// out-of-range and illegal-size requests return rsp_err=1 and never write.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req_valid/ready     request handshake
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I load/store funct3
//   req_addr            byte address (word index = addr[31:2])
//   req_wdata           store data, bytes taken from the LSBs
//   rsp_valid/ready     response handshake
//   rsp_rdata           extended load data; 0 for stores and errors
//   rsp_err             request rejected, no memory update
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LastCnt = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        commit;

  logic [31:0] mem [DEPTH_WORDS];

  // Access fields: with zero wait the commit happens on the accept edge, so
  // the live request is used; otherwise the latched copy.
  logic            acc_we;
  logic [2:0]      acc_f3;
  logic [31:0]     acc_addr, acc_wdata;
  logic [IdxW-1:0] idx;
  logic            illegal, misaligned, out_of_range, acc_err;
  logic [3:0]      be;
  logic [31:0]     wword, rword, shifted, load_val;

  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    idx = acc_addr[IdxW+1:2];
    unique case (acc_f3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = acc_we;   // unsigned forms exist for loads only
      default:                illegal = 1'b1;
    endcase
    misaligned   = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                   ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, acc_addr[31:2]} >= DEPTH_WORDS);
    acc_err      = illegal || misaligned || out_of_range;

    rword   = mem[idx];
    shifted = rword >> {acc_addr[1:0], 3'b000};
    unique case (acc_f3[1:0])
      2'b00: begin
        be       = 4'b0001 << acc_addr[1:0];
        wword    = {4{acc_wdata[7:0]}};
        load_val = acc_f3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be       = 4'b0011 << acc_addr[1:0];
        wword    = {2{acc_wdata[15:0]}};
        load_val = acc_f3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be       = 4'b1111;
        wword    = acc_wdata;
        load_val = rword;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_we || acc_err) ? 32'd0 : load_val;
      end
    end
  end

  // Storage is not reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (rst_n && commit && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == LastCnt) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule
